// File: rtl/jtag_scan_ctrl.sv
// jtag_scan_ctrl: turns IR/DR scan and TAP-reset requests into TCK/TMS/TDI
// waveforms and returns the TDO bits captured during the shift.
// Optional build macro JTAG_SCAN_RTI_PAD_EN: adds 4 TCK in Run-Test/Idle
// after Update, before the response is posted.
module jtag_scan_ctrl #(
  parameter int CLK_DIV = 4,
  parameter int MAX_LEN = 64,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic               req_tap_rst_i,
  input  logic               req_ir_i,
  input  logic [LEN_W-1:0]   req_len_i,
  input  logic [MAX_LEN-1:0] req_data_i,
  output logic               rsp_valid_o,
  input  logic               rsp_ready_i,
  output logic [MAX_LEN-1:0] rsp_data_o,
  output logic               rsp_err_o,
  output logic               jtag_tck_o,
  output logic               jtag_tms_o,
  output logic               jtag_tdi_o,
  input  logic               jtag_tdo_i,
  output logic               jtag_trst_no,
  output logic               busy_o
);

  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = {{(DIV_W-1){1'b0}}, 1'b1};
  localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    PREFIX  = 4'd1,
    TLR5    = 4'd2,
    SEL     = 4'd3,
    CAPTURE = 4'd4,
    SHIFT   = 4'd5,
    EXIT1   = 4'd6,
    UPDATE  = 4'd7,
    PAD     = 4'd8,
    RSP     = 4'd9
  } state_t;

  state_t               state_r;
  logic [LEN_W-1:0]     cnt_r;      // TCK index within the current state
  logic [DIV_W-1:0]     div_cnt_r;  // clk_i cycles within the TCK half-period
  logic                 arm_r;      // next half-period boundary opens the first TCK
  logic                 tlr_flag_r; // TAP may sit in Test-Logic-Reset
  logic                 ir_r;
  logic [LEN_W-1:0]     len_r;
  logic [MAX_LEN-1:0]   data_r;
  logic                 len_bad_s;

  assign len_bad_s = (req_len_i == {LEN_W{1'b0}}) || (req_len_i > LEN_MAX);

  // Index of the last TCK spent in a state.
  function automatic logic [LEN_W-1:0] last_idx(input state_t st, input logic ir,
                                                input logic [LEN_W-1:0] len);
    case (st)
      TLR5:    last_idx = LEN_W'(3'd5);
      SEL:     last_idx = ir ? LEN_ONE : {LEN_W{1'b0}};
      CAPTURE: last_idx = LEN_ONE;
      SHIFT:   last_idx = len - LEN_ONE;
      PAD:     last_idx = LEN_W'(2'd3);
      default: last_idx = {LEN_W{1'b0}};
    endcase
  endfunction

  // State entered after the last TCK of a state.
  function automatic state_t next_state(input state_t st);
    case (st)
      PREFIX:  next_state = SEL;
      TLR5:    next_state = RSP;
      SEL:     next_state = CAPTURE;
      CAPTURE: next_state = SHIFT;
      SHIFT:   next_state = EXIT1;
      EXIT1:   next_state = UPDATE;
`ifdef JTAG_SCAN_RTI_PAD_EN
      UPDATE:  next_state = PAD;
`else
      UPDATE:  next_state = RSP;
`endif
      PAD:     next_state = RSP;
      default: next_state = IDLE;
    endcase
  endfunction

  // TMS level driven during TCK number c of state st.
  function automatic logic tms_of(input state_t st, input logic [LEN_W-1:0] c,
                                  input logic [LEN_W-1:0] len);
    case (st)
      TLR5:    tms_of = (c != LEN_W'(3'd5));
      SEL:     tms_of = 1'b1;
      SHIFT:   tms_of = (c == len - LEN_ONE);
      EXIT1:   tms_of = 1'b1;
      default: tms_of = 1'b0;
    endcase
  endfunction

  // TDI level driven during TCK number c of state st.
  function automatic logic tdi_of(input state_t st, input logic [LEN_W-1:0] c,
                                  input logic [MAX_LEN-1:0] data);
    tdi_of = (st == SHIFT) ? data[c[IDX_W-1:0]] : 1'b0;
  endfunction

  // Request/response handshake, TCK generation and scan sequencing.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r      <= IDLE;
      cnt_r        <= {LEN_W{1'b0}};
      div_cnt_r    <= {DIV_W{1'b0}};
      arm_r        <= 1'b0;
      tlr_flag_r   <= 1'b1;
      ir_r         <= 1'b0;
      len_r        <= {LEN_W{1'b0}};
      data_r       <= {MAX_LEN{1'b0}};
      req_ready_o  <= 1'b0;
      rsp_valid_o  <= 1'b0;
      rsp_data_o   <= {MAX_LEN{1'b0}};
      rsp_err_o    <= 1'b0;
      jtag_tck_o   <= 1'b0;
      jtag_tms_o   <= 1'b1;
      jtag_tdi_o   <= 1'b0;
      jtag_trst_no <= 1'b0;
      busy_o       <= 1'b0;
    end else begin
      jtag_trst_no <= 1'b1;
      case (state_r)
        IDLE: begin
          if (req_valid_i && req_ready_o) begin
            req_ready_o <= 1'b0;
            busy_o      <= 1'b1;
            rsp_data_o  <= {MAX_LEN{1'b0}};
            rsp_err_o   <= 1'b0;
            ir_r        <= req_ir_i;
            len_r       <= req_len_i;
            data_r      <= req_data_i;
            cnt_r       <= {LEN_W{1'b0}};
            div_cnt_r   <= DIV_LAST;
            arm_r       <= 1'b1;
            if (req_tap_rst_i) begin
              state_r    <= TLR5;
              tlr_flag_r <= 1'b0;
            end else if (len_bad_s) begin
              state_r <= RSP;
            end else begin
              state_r    <= tlr_flag_r ? PREFIX : SEL;
              tlr_flag_r <= 1'b0;
            end
          end else begin
            req_ready_o <= 1'b1;
          end
        end
        PREFIX, TLR5, SEL, CAPTURE, SHIFT, EXIT1, UPDATE, PAD: begin
          if (div_cnt_r != DIV_LAST) begin
            div_cnt_r <= div_cnt_r + DIV_ONE;
          end else begin
            div_cnt_r <= {DIV_W{1'b0}};
            if (arm_r) begin
              // Start of the first low phase: present the first TMS/TDI.
              arm_r      <= 1'b0;
              jtag_tms_o <= tms_of(state_r, cnt_r, len_r);
              jtag_tdi_o <= tdi_of(state_r, cnt_r, data_r);
            end else if (!jtag_tck_o) begin
              jtag_tck_o <= 1'b1;
              if (state_r == SHIFT) begin
                rsp_data_o[cnt_r[IDX_W-1:0]] <= jtag_tdo_i;
              end
            end else begin
              jtag_tck_o <= 1'b0;
              if (cnt_r != last_idx(state_r, ir_r, len_r)) begin
                cnt_r      <= cnt_r + LEN_ONE;
                jtag_tms_o <= tms_of(state_r, cnt_r + LEN_ONE, len_r);
                jtag_tdi_o <= tdi_of(state_r, cnt_r + LEN_ONE, data_r);
              end else if (next_state(state_r) == RSP) begin
                state_r     <= RSP;
                rsp_valid_o <= 1'b1;
                busy_o      <= 1'b0;
                jtag_tms_o  <= 1'b0;
                jtag_tdi_o  <= 1'b0;
              end else begin
                state_r    <= next_state(state_r);
                cnt_r      <= {LEN_W{1'b0}};
                jtag_tms_o <= tms_of(next_state(state_r), {LEN_W{1'b0}}, len_r);
                jtag_tdi_o <= tdi_of(next_state(state_r), {LEN_W{1'b0}}, data_r);
              end
            end
          end
        end
        RSP: begin
          if (!rsp_valid_o) begin
            // Only an illegal length arrives here without a posted response.
            rsp_valid_o <= 1'b1;
            rsp_err_o   <= 1'b1;
            busy_o      <= 1'b0;
            arm_r       <= 1'b0;
          end else if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            req_ready_o <= 1'b1;
            state_r     <= IDLE;
          end
        end
        default: begin
          state_r     <= IDLE;
          jtag_tck_o  <= 1'b0;
          rsp_valid_o <= 1'b0;
          busy_o      <= 1'b0;
          req_ready_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
